// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package riscv_mem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_lat_tracker.sv
// Read-latency down-counter with owner tag; done marks the cycle read data is valid.
module arb_lat_tracker
  import riscv_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  owner_e load_owner,
  output logic   done,
  output owner_e owner,
  output logic   busy
);

  logic [LAT_W-1:0] cnt;

  // A load in the done cycle overrides the final decrement (back-to-back reads).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      owner <= OWN_IF;
    end else if (load) begin
      cnt   <= LAT_W'(RD_LAT);
      owner <= load_owner;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign done = !rst && (cnt == LAT_W'(1));
  assign busy = !rst && (cnt > LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a shared single-port block RAM with one outstanding read.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_cfg_err
    $error("mem_port_arbiter: RD_LAT or MAX_WAIT out of range");
  end

  arb_state_e state;
  logic       grant_ok;
  logic       promote;
  logic       rd_load;
  owner_e     rd_owner;
  logic       lat_done;
  logic       lat_busy;
  owner_e     lat_owner;

  // The done cycle behaves as IDLE so a new grant can follow immediately.
  assign grant_ok = !rst && ((state == IDLE) || lat_done);

`ifdef ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      if (starve_cnt != '1) starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  assign promote = if_req && (starve_cnt == STARVE_W'(MAX_WAIT));
`else
  assign promote = 1'b0;
`endif

  // Grant selection and RAM drive; everything zero when nobody wins.
  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_load   = 1'b0;
    rd_owner  = OWN_IF;
    if (grant_ok && d_req && !promote) begin
      d_gnt     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = {4{d_we}} & d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      rd_load   = !d_we;
      rd_owner  = OWN_D;
    end else if (grant_ok && if_req) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = if_addr;
      rd_load  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (rd_load) state <= WAIT;
        WAIT:    if (lat_done && !rd_load) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  arb_lat_tracker #(
    .RD_LAT (RD_LAT)
  ) u_lat (
    .clk        (clk),
    .rst        (rst),
    .load       (rd_load),
    .load_owner (rd_owner),
    .done       (lat_done),
    .owner      (lat_owner),
    .busy       (lat_busy)
  );

  assign if_rvalid = lat_done && (lat_owner == OWN_IF);
  assign d_rvalid  = lat_done && (lat_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign busy      = lat_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model with a shadow RAM.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [31:0] init_word(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Environment RAM driven by the DUT's mem_* pins; garbage on mem_rdata when no read is due.
  logic [31:0] ram     [DEPTH];
  bit          ram_set [DEPTH];
  logic [31:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    logic [31:0] w;
    w = ram_set[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
    if (mem_en && mem_we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      ram[mem_addr]     <= w;
      ram_set[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && mem_we == 4'b0000) ? w : $urandom;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: one pending read with cycles remaining, shadow memory, starvation count.
  logic [31:0] mram [DEPTH];
  bit          pend;
  bit          pown;
  int          rem;
  logic [31:0] pdata;
  int          scnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit free, rv, promote, dg, ig;
    free    = !pend || rem == 0;
    rv      = !rst && pend && rem == 0;
    promote = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    promote = if_req && scnt == int'(MAX_WAIT);
`endif
    dg = !rst && free && d_req && !promote;
    ig = !rst && free && if_req && !dg;

    check("if_gnt",    32'(if_gnt),    32'(ig));
    check("d_gnt",     32'(d_gnt),     32'(dg));
    check("if_rvalid", 32'(if_rvalid), 32'(rv && !pown));
    check("d_rvalid",  32'(d_rvalid),  32'(rv && pown));
    check("if_rdata",  if_rdata, (rv && !pown) ? pdata : 32'h0);
    check("d_rdata",   d_rdata,  (rv && pown) ? pdata : 32'h0);
    check("busy",      32'(busy),      32'(!rst && pend && rem > 0));
    check("mem_en",    32'(mem_en),    32'(dg || ig));
    check("mem_we",    32'(mem_we),    (dg && d_we) ? 32'(d_be) : 32'h0);
    check("mem_addr",  32'(mem_addr),  dg ? 32'(d_addr) : (ig ? 32'(if_addr) : 32'h0));
    check("mem_wdata", mem_wdata,      dg ? d_wdata : 32'h0);

    if (rst) begin
      pend = 1'b0;
      rem  = 0;
      scnt = 0;
    end else begin
      if (pend) begin
        if (rem == 0) pend = 1'b0;
        else rem--;
      end
      if (dg && d_we) begin
        for (int b = 0; b < 4; b++)
          if (d_be[b]) mram[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
      end else if (dg || ig) begin
        pend  = 1'b1;
        pown  = dg;
        rem   = int'(RD_LAT) - 1;
        pdata = dg ? mram[d_addr] : mram[if_addr];
      end
      if (if_req && !ig) scnt = (scnt < 15) ? scnt + 1 : 15;
      else scnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'b0000;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  initial begin
    bit exp_if;
    for (int a = 0; a < int'(DEPTH); a++) mram[a] = init_word(a);
    pend = 1'b0; pown = 1'b0; rem = 0; pdata = '0; scnt = 0;
    rst = 1'b1;
    idle_inputs();

    // Reset state
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    adv();
    if_req = 1'b1; d_req = 1'b1;
    tick();
    check("rst_no_grant", 32'({if_gnt, d_gnt, mem_en}), 32'h0);
    adv();
    rst = 1'b0;
    idle_inputs();
    tick(); adv();

    // Fetch-only read of 0x010, request dropped after the grant
    if_req = 1'b1; if_addr = 12'h010;
    tick();
    check("t1_if_gnt", 32'(if_gnt), 32'h1);
    check("t1_mem_addr", 32'(mem_addr), 32'h010);
    adv();
    idle_inputs();
    tick();
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_no_rvalid_early", 32'(if_rvalid), 32'h0);
    adv();
    tick();
    check("t1_if_rvalid", 32'(if_rvalid), 32'h1);
    check("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check("t1_d_rvalid", 32'(d_rvalid), 32'h0);
    adv();

    // Simultaneous read requests: data first, fetch on the data rvalid cycle
    if_req = 1'b1; if_addr = 12'h030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
    tick();
    check("t2_d_gnt", 32'(d_gnt), 32'h1);
    check("t2_if_lose", 32'(if_gnt), 32'h0);
    adv();
    d_req = 1'b0;
    tick();
    check("t2_wait_no_gnt", 32'(if_gnt), 32'h0);
    adv();
    tick();
    check("t2_d_rvalid", 32'(d_rvalid), 32'h1);
    check("t2_d_rdata", d_rdata, init_word(32));
    check("t2_if_gnt", 32'(if_gnt), 32'h1);
    adv();
    if_req = 1'b0;
    tick(); adv();
    tick();
    check("t2_if_rvalid", 32'(if_rvalid), 32'h1);
    check("t2_if_rdata", if_rdata, init_word(48));
    adv();

    // Three back-to-back half-word writes
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
      d_addr = ADDR_W'(12'h040 + i); d_wdata = $urandom;
      tick();
      check("t3_d_gnt", 32'(d_gnt), 32'h1);
      check("t3_mem_we", 32'(mem_we), 32'h3);
      check("t3_busy", 32'(busy), 32'h0);
      adv();
    end
    idle_inputs();
    tick(); adv();

    // Writes hog the port while fetch waits
    for (int i = 0; i < 5; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
      d_addr = ADDR_W'(12'h060 + i); d_wdata = $urandom;
      if_req = 1'b1; if_addr = 12'h050;
      exp_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (i == 4);
`endif
      tick();
      check("t4_if_gnt", 32'(if_gnt), 32'(exp_if));
      check("t4_d_gnt", 32'(d_gnt), 32'(!exp_if));
      adv();
    end
    idle_inputs();
    for (int i = 0; i < int'(RD_LAT) + 1; i++) begin tick(); adv(); end

    // Reset pulsed while a read is outstanding
    if_req = 1'b1; if_addr = 12'h011;
    tick();
    check("t5_if_gnt", 32'(if_gnt), 32'h1);
    adv();
    idle_inputs();
    rst = 1'b1;
    tick();
    check("t5_rst_busy", 32'(busy), 32'h0);
    adv();
    rst = 1'b0;
    tick();
    check("t5_no_rvalid", 32'({if_rvalid, d_rvalid}), 32'h0);
    check("t5_idle_busy", 32'(busy), 32'h0);
    adv();

    // Random traffic on a small address window
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      if_req  = ($urandom_range(0, 9) < 6);
      if_addr = ADDR_W'($urandom_range(0, 63));
      d_req   = ($urandom_range(0, 9) < 5);
      d_we    = $urandom_range(0, 1) == 1;
      d_be    = 4'($urandom);
      d_addr  = ADDR_W'($urandom_range(0, 63));
      d_wdata = $urandom;
      tick();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
